// File: rtl/turfio_aurora_tx_arbiter.sv
// Per-lane TX arbiter between a framed data stream and UFC messages in front of the Aurora TX ports.
// Optional saturating frame/UFC counters are built when TURFIO_TX_ARB_STATS_EN is defined.
module turfio_aurora_tx_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                  user_clk,
  input  logic                                  reset,
  input  logic [NUM_LANES-1:0]                  channel_up,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]       s_data_tdata,
  input  logic [NUM_LANES*(DATA_WIDTH/8)-1:0]   s_data_tkeep,
  input  logic [NUM_LANES-1:0]                  s_data_tlast,
  input  logic [NUM_LANES-1:0]                  s_data_tvalid,
  output logic [NUM_LANES-1:0]                  s_data_tready,
  input  logic [3*NUM_LANES-1:0]                s_ufc_tsize,
  input  logic [NUM_LANES-1:0]                  s_ufc_tvalid,
  output logic [NUM_LANES-1:0]                  s_ufc_tready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]       s_ufcd_tdata,
  input  logic [NUM_LANES-1:0]                  s_ufcd_tlast,
  input  logic [NUM_LANES-1:0]                  s_ufcd_tvalid,
  output logic [NUM_LANES-1:0]                  s_ufcd_tready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]       m_tx_tdata,
  output logic [NUM_LANES*(DATA_WIDTH/8)-1:0]   m_tx_tkeep,
  output logic [NUM_LANES-1:0]                  m_tx_tlast,
  output logic [NUM_LANES-1:0]                  m_tx_tvalid,
  input  logic [NUM_LANES-1:0]                  m_tx_tready,
  output logic [3*NUM_LANES-1:0]                m_ufc_tdata,
  output logic [NUM_LANES-1:0]                  m_ufc_tvalid,
  input  logic [NUM_LANES-1:0]                  m_ufc_tready,
  output logic [NUM_LANES-1:0]                  frame_abort,
  output logic [NUM_LANES-1:0]                  ufc_len_err,
  output logic [16*NUM_LANES-1:0]               stat_frames,
  output logic [16*NUM_LANES-1:0]               stat_ufc,
  output logic [3*NUM_LANES-1:0]                dbg_state
);

  localparam int KW = DATA_WIDTH / 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DATA       = 3'd1;
  localparam logic [2:0] ST_UFC_HDR    = 3'd2;
  localparam logic [2:0] ST_UFC_PAY    = 3'd3;
  localparam logic [2:0] ST_DRAIN_DATA = 3'd4;
  localparam logic [2:0] ST_DRAIN_UFC  = 3'd5;

  // Every port pair is AXI4-Stream: a beat moves on a user_clk rising edge where valid and ready
  // are both high; ready may depend combinationally on valid, valid never waits for ready.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [2:0]            state, state_nxt, tsize_q, cnt_q;
    logic                  ufc_v_q, abort_q, lerr_q;
    logic                  cu, dv, dl, uv, udv, udl, mrdy;
    logic                  dr, ur, udr, tv, tl;
    logic [DATA_WIDTH-1:0] td;
    logic [KW-1:0]         tk;
    logic                  abort_nxt, lerr_nxt, load_cnt, dec_cnt, latch_sz;

    assign cu   = channel_up[i];
    assign dv   = s_data_tvalid[i];
    assign dl   = s_data_tlast[i];
    assign uv   = s_ufc_tvalid[i];
    assign udv  = s_ufcd_tvalid[i];
    assign udl  = s_ufcd_tlast[i];
    assign mrdy = m_tx_tready[i];

    always_comb begin
      state_nxt = state;
      dr        = 1'b0;
      ur        = 1'b0;
      udr       = 1'b0;
      tv        = 1'b0;
      td        = s_data_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      tk        = s_data_tkeep[i*KW +: KW];
      tl        = dl;
      abort_nxt = 1'b0;
      lerr_nxt  = 1'b0;
      load_cnt  = 1'b0;
      dec_cnt   = 1'b0;
      latch_sz  = 1'b0;
      case (state)
        ST_IDLE: begin
          if (cu) begin
            if (uv) begin
              latch_sz  = 1'b1;
              state_nxt = ST_UFC_HDR;
            end else begin
              tv = dv;
              dr = mrdy;
              if (dv && mrdy && !dl) state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!cu) begin
            state_nxt = ST_DRAIN_DATA;
            abort_nxt = 1'b1;
          end else begin
            tv = dv;
            dr = mrdy;
            if (dv && mrdy && dl) state_nxt = ST_IDLE;
          end
        end
        ST_UFC_HDR: begin
          if (!cu) begin
            state_nxt = ST_IDLE;
          end else if (m_ufc_tready[i]) begin
            ur        = 1'b1;
            load_cnt  = 1'b1;
            state_nxt = ST_UFC_PAY;
          end
        end
        ST_UFC_PAY: begin
          td = s_ufcd_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          tk = '1;
          tl = 1'b0;
          if (!cu) begin
            state_nxt = ST_DRAIN_UFC;
            abort_nxt = 1'b1;
          end else begin
            tv  = udv;
            udr = mrdy;
            if (udv && mrdy) begin
              // Length comes from tsize alone; tlast is only cross-checked.
              lerr_nxt = (udl != (cnt_q == 3'd0));
              dec_cnt  = 1'b1;
              if (cnt_q == 3'd0) state_nxt = ST_IDLE;
            end
          end
        end
        ST_DRAIN_DATA: begin
          dr = 1'b1;
          if (dv && dl) state_nxt = ST_IDLE;
        end
        ST_DRAIN_UFC: begin
          udr = 1'b1;
          if (udv) begin
            dec_cnt = 1'b1;
            if (cnt_q == 3'd0) state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge user_clk) begin
      if (reset) begin
        state   <= ST_IDLE;
        tsize_q <= 3'd0;
        cnt_q   <= 3'd0;
        ufc_v_q <= 1'b0;
        abort_q <= 1'b0;
        lerr_q  <= 1'b0;
      end else begin
        state <= state_nxt;
        if (latch_sz) tsize_q <= s_ufc_tsize[3*i +: 3];
        if (load_cnt)     cnt_q <= tsize_q;
        else if (dec_cnt) cnt_q <= cnt_q - 3'd1;
        ufc_v_q <= (state_nxt == ST_UFC_HDR);
        abort_q <= abort_nxt;
        lerr_q  <= lerr_nxt;
      end
    end

    assign s_data_tready[i]                      = dr;
    assign s_ufc_tready[i]                       = ur;
    assign s_ufcd_tready[i]                      = udr;
    assign m_tx_tdata[i*DATA_WIDTH +: DATA_WIDTH] = td;
    assign m_tx_tkeep[i*KW +: KW]                 = tk;
    assign m_tx_tlast[i]                          = tl;
    assign m_tx_tvalid[i]                         = tv;
    assign m_ufc_tdata[3*i +: 3]                  = tsize_q;
    assign m_ufc_tvalid[i]                        = ufc_v_q;
    assign frame_abort[i]                         = abort_q;
    assign ufc_len_err[i]                         = lerr_q;
    assign dbg_state[3*i +: 3]                    = state;

`ifdef TURFIO_TX_ARB_STATS_EN
    logic [15:0] frames_q, ufc_q;
    logic        frame_inc;

    // Drained beats never reach m_tx, so only real forwarded frame ends count.
    assign frame_inc = tv && mrdy && tl && ((state == ST_IDLE) || (state == ST_DATA));

    always_ff @(posedge user_clk) begin
      if (reset) begin
        frames_q <= 16'd0;
        ufc_q    <= 16'd0;
      end else begin
        if (frame_inc && (frames_q != 16'hFFFF)) frames_q <= frames_q + 16'd1;
        if (ur && (ufc_q != 16'hFFFF))           ufc_q    <= ufc_q + 16'd1;
      end
    end

    assign stat_frames[16*i +: 16] = frames_q;
    assign stat_ufc[16*i +: 16]    = ufc_q;
`else
    assign stat_frames[16*i +: 16] = 16'd0;
    assign stat_ufc[16*i +: 16]    = 16'd0;
`endif
  end

endmodule

// File: tb/tb_turfio_aurora_tx_arbiter.sv
// Directed and randomized bench for turfio_aurora_tx_arbiter (4 lanes x 16 bit).
// Expected counter values follow TURFIO_TX_ARB_STATS_EN when the bench is built with it.
module tb_turfio_aurora_tx_arbiter;
  localparam int L = 4;
  localparam int W = 16;
  localparam int K = 2;

  logic           user_clk = 1'b0;
  logic           reset = 1'b1;
  logic [L-1:0]   channel_up = '1;
  logic [L*W-1:0] s_data_tdata = '0;
  logic [L*K-1:0] s_data_tkeep = '1;
  logic [L-1:0]   s_data_tlast = '0;
  logic [L-1:0]   s_data_tvalid = '0;
  logic [L-1:0]   s_data_tready;
  logic [3*L-1:0] s_ufc_tsize = '0;
  logic [L-1:0]   s_ufc_tvalid = '0;
  logic [L-1:0]   s_ufc_tready;
  logic [L*W-1:0] s_ufcd_tdata = '0;
  logic [L-1:0]   s_ufcd_tlast = '0;
  logic [L-1:0]   s_ufcd_tvalid = '0;
  logic [L-1:0]   s_ufcd_tready;
  logic [L*W-1:0] m_tx_tdata;
  logic [L*K-1:0] m_tx_tkeep;
  logic [L-1:0]   m_tx_tlast;
  logic [L-1:0]   m_tx_tvalid;
  logic [L-1:0]   m_tx_tready = '1;
  logic [3*L-1:0] m_ufc_tdata;
  logic [L-1:0]   m_ufc_tvalid;
  logic [L-1:0]   m_ufc_tready = '1;
  logic [L-1:0]   frame_abort;
  logic [L-1:0]   ufc_len_err;
  logic [16*L-1:0] stat_frames;
  logic [16*L-1:0] stat_ufc;
  logic [3*L-1:0] dbg_state;

  turfio_aurora_tx_arbiter #(.NUM_LANES(L), .DATA_WIDTH(W)) dut (
    .user_clk(user_clk), .reset(reset), .channel_up(channel_up),
    .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .s_ufc_tsize(s_ufc_tsize), .s_ufc_tvalid(s_ufc_tvalid), .s_ufc_tready(s_ufc_tready),
    .s_ufcd_tdata(s_ufcd_tdata), .s_ufcd_tlast(s_ufcd_tlast), .s_ufcd_tvalid(s_ufcd_tvalid),
    .s_ufcd_tready(s_ufcd_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tkeep(m_tx_tkeep), .m_tx_tlast(m_tx_tlast),
    .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
    .m_ufc_tdata(m_ufc_tdata), .m_ufc_tvalid(m_ufc_tvalid), .m_ufc_tready(m_ufc_tready),
    .frame_abort(frame_abort), .ufc_len_err(ufc_len_err),
    .stat_frames(stat_frames), .stat_ufc(stat_ufc), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 user_clk = ~user_clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  bit rnd_en = 1'b0;
  bit mon_en = 1'b0;
  logic [18:0] exp_q[$];
  logic [2:0]  hdr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL timeout %s observed=no_handshake expected=handshake", tag);
  endtask

  function automatic logic [15:0] exp_stat(input int n);
`ifdef TURFIO_TX_ARB_STATS_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  // Lane 2 output monitor for the randomized phase.
  always @(negedge user_clk) begin
    if (mon_en && m_tx_tvalid[2] && m_tx_tready[2]) begin
      if (exp_q.size() == 0) chk("rnd_unexpected_beat", {13'd0, m_tx_tlast[2], m_tx_tkeep[5:4], m_tx_tdata[47:32]}, 32'hFFFF_FFFF);
      else chk("rnd_beat", {13'd0, m_tx_tlast[2], m_tx_tkeep[5:4], m_tx_tdata[47:32]}, {13'd0, exp_q.pop_front()});
    end
    if (mon_en && m_ufc_tvalid[2] && m_ufc_tready[2]) begin
      if (hdr_q.size() == 0) chk("rnd_unexpected_hdr", {29'd0, m_ufc_tdata[8:6]}, 32'hFFFF_FFFF);
      else chk("rnd_hdr", {29'd0, m_ufc_tdata[8:6]}, {29'd0, hdr_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge user_clk);
    #1;
    if (rnd_en) begin
      m_tx_tready[2]  = ($urandom_range(0, 3) != 0);
      m_ufc_tready[2] = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic set_data(input int ln, input logic v, input logic [15:0] d, input logic l);
    s_data_tvalid[ln]       = v;
    s_data_tdata[ln*W +: W] = d;
    s_data_tlast[ln]        = l;
    s_data_tkeep[ln*K +: K] = 2'b11;
  endtask

  task automatic set_ufcd(input int ln, input logic v, input logic [15:0] d, input logic l);
    s_ufcd_tvalid[ln]       = v;
    s_ufcd_tdata[ln*W +: W] = d;
    s_ufcd_tlast[ln]        = l;
  endtask

  function automatic logic rdy_of(input int sel);
    case (sel)
      0:       return s_data_tready[2];
      1:       return s_ufc_tready[2];
      default: return s_ufcd_tready[2];
    endcase
  endfunction

  // Hold the current lane 2 beat until it is accepted, then step past the transfer edge.
  task automatic wait_hs(input int sel, input string tag);
    int n = 0;
    #1;
    while (!rdy_of(sel)) begin
      tick;
      #1;
      n++;
      if (n > 300) begin
        timeout(tag);
        break;
      end
    end
    tick;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    int nf;
    int nu;
    int len;
    logic [2:0]  sz;
    logic [15:0] d;
    logic [1:0]  k;

    repeat (3) tick;
    reset = 1'b0;
    #1;
    chk("rst_m_ufc_tvalid", {28'd0, m_ufc_tvalid}, 32'd0);
    chk("rst_frame_abort", {28'd0, frame_abort}, 32'd0);
    chk("rst_ufc_len_err", {28'd0, ufc_len_err}, 32'd0);
    chk("rst_stat_frames", stat_frames[31:0] | stat_frames[63:32], 32'd0);
    chk("rst_stat_ufc", stat_ufc[31:0] | stat_ufc[63:32], 32'd0);
    chk("rst_s_ufc_tready", {28'd0, s_ufc_tready}, 32'd0);
    chk("rst_m_tx_tvalid", {28'd0, m_tx_tvalid}, 32'd0);
    tick;

    // 1: lane 0 three-beat frame passes through with zero latency
    set_data(0, 1'b1, 16'h1111, 1'b0); #1;
    chk("t1_b0_valid", {31'd0, m_tx_tvalid[0]}, 32'd1);
    chk("t1_b0_data", {16'd0, m_tx_tdata[15:0]}, 32'h1111);
    chk("t1_b0_ready", {31'd0, s_data_tready[0]}, 32'd1);
    tick;
    set_data(0, 1'b1, 16'h2222, 1'b0); #1;
    chk("t1_b1_data", {16'd0, m_tx_tdata[15:0]}, 32'h2222);
    chk("t1_b1_last", {31'd0, m_tx_tlast[0]}, 32'd0);
    tick;
    set_data(0, 1'b1, 16'h3333, 1'b1); #1;
    chk("t1_b2_data", {16'd0, m_tx_tdata[15:0]}, 32'h3333);
    chk("t1_b2_last", {31'd0, m_tx_tlast[0]}, 32'd1);
    tick;
    set_data(0, 1'b0, 16'h0, 1'b0); #1;
    chk("t1_idle_valid", {31'd0, m_tx_tvalid[0]}, 32'd0);
    chk("t1_stat_frames", {16'd0, stat_frames[15:0]}, {16'd0, exp_stat(1)});

    // 2: lane 1 UFC beats a simultaneous data frame
    s_ufc_tvalid[1] = 1'b1;
    s_ufc_tsize[5:3] = 3'd2;
    set_data(1, 1'b1, 16'hAAAA, 1'b1); #1;
    chk("t2_idle_data_blocked", {31'd0, s_data_tready[1]}, 32'd0);
    chk("t2_idle_tx_valid", {31'd0, m_tx_tvalid[1]}, 32'd0);
    tick; #1;
    chk("t2_hdr_valid", {31'd0, m_ufc_tvalid[1]}, 32'd1);
    chk("t2_hdr_tdata", {29'd0, m_ufc_tdata[5:3]}, 32'd2);
    chk("t2_hdr_ready", {31'd0, s_ufc_tready[1]}, 32'd1);
    chk("t2_hdr_data_blocked", {31'd0, s_data_tready[1]}, 32'd0);
    tick;
    s_ufc_tvalid[1] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_ufcd(1, 1'b1, 16'hB000 + 16'(b), (b == 2)); #1;
      chk("t2_pay_valid", {31'd0, m_tx_tvalid[1]}, 32'd1);
      chk("t2_pay_data", {16'd0, m_tx_tdata[31:16]}, 32'hB000 + b);
      chk("t2_pay_last_keep", {29'd0, m_tx_tlast[1], m_tx_tkeep[3:2]}, 32'd3);
      chk("t2_pay_data_blocked", {31'd0, s_data_tready[1]}, 32'd0);
      chk("t2_pay_ufc_tvalid", {31'd0, m_ufc_tvalid[1]}, 32'd0);
      tick;
    end
    set_ufcd(1, 1'b0, 16'h0, 1'b0); #1;
    chk("t2_len_err", {31'd0, ufc_len_err[1]}, 32'd0);
    chk("t2_data_after", {15'd0, m_tx_tvalid[1], m_tx_tdata[31:16]}, 32'h1AAAA);
    chk("t2_data_after_last", {31'd0, m_tx_tlast[1]}, 32'd1);
    chk("t2_stat_ufc", {16'd0, stat_ufc[31:16]}, {16'd0, exp_stat(1)});
    tick;
    set_data(1, 1'b0, 16'h0, 1'b0);

    // 3: lane 2 backpressure 1,0,1,0 over a four-beat frame
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      m_tx_tready[2] = ((c % 2) == 0);
      set_data(2, 1'b1, 16'hC000 + 16'(nb), (nb == 3)); #1;
      chk("t3_data", {16'd0, m_tx_tdata[47:32]}, 32'hC000 + nb);
      chk("t3_ready_follows", {31'd0, s_data_tready[2]}, {31'd0, m_tx_tready[2]});
      if (s_data_tready[2] && m_tx_tvalid[2]) nb++;
      tick;
    end
    set_data(2, 1'b0, 16'h0, 1'b0);
    m_tx_tready[2] = 1'b1;
    chk("t3_beats_out", nb, 32'd4);

    // 4: lane 3 channel loss mid-frame drains the rest
    set_data(3, 1'b1, 16'h4001, 1'b0); #1;
    chk("t4_b1_pass", {15'd0, m_tx_tvalid[3], m_tx_tdata[63:48]}, 32'h14001);
    tick;
    set_data(3, 1'b1, 16'h4002, 1'b0); #1;
    chk("t4_b2_pass", {15'd0, m_tx_tvalid[3], m_tx_tdata[63:48]}, 32'h14002);
    tick;
    channel_up[3] = 1'b0;
    set_data(3, 1'b1, 16'h4003, 1'b0); #1;
    chk("t4_loss_valid", {31'd0, m_tx_tvalid[3]}, 32'd0);
    tick; #1;
    chk("t4_abort_pulse", {31'd0, frame_abort[3]}, 32'd1);
    chk("t4_drain_valid", {31'd0, m_tx_tvalid[3]}, 32'd0);
    chk("t4_drain_ready", {31'd0, s_data_tready[3]}, 32'd1);
    tick;
    set_data(3, 1'b1, 16'h4004, 1'b0); #1;
    chk("t4_abort_once", {31'd0, frame_abort[3]}, 32'd0);
    chk("t4_drain_valid_b4", {30'd0, m_tx_tvalid[3], s_data_tready[3]}, 32'd1);
    tick;
    set_data(3, 1'b1, 16'h4005, 1'b1); #1;
    chk("t4_drain_valid_b5", {30'd0, m_tx_tvalid[3], s_data_tready[3]}, 32'd1);
    tick;
    channel_up[3] = 1'b1;
    set_data(3, 1'b1, 16'h4EEE, 1'b1); #1;
    chk("t4_idle_again", {15'd0, m_tx_tvalid[3], m_tx_tdata[63:48]}, 32'h14EEE);
    tick;
    set_data(3, 1'b0, 16'h0, 1'b0); #1;
    chk("t4_stat_frames", {16'd0, stat_frames[63:48]}, {16'd0, exp_stat(1)});

    // 5: lane 0 tsize=1 with early tlast on the first payload beat
    s_ufc_tvalid[0] = 1'b1;
    s_ufc_tsize[2:0] = 3'd1;
    tick; #1;
    chk("t5_hdr_tdata", {28'd0, m_ufc_tvalid[0], m_ufc_tdata[2:0]}, 32'h9);
    tick;
    s_ufc_tvalid[0] = 1'b0;
    set_ufcd(0, 1'b1, 16'h5001, 1'b1); #1;
    chk("t5_b0_fwd", {15'd0, m_tx_tvalid[0], m_tx_tdata[15:0]}, 32'h15001);
    tick;
    set_ufcd(0, 1'b1, 16'h5002, 1'b1); #1;
    chk("t5_len_err_pulse", {31'd0, ufc_len_err[0]}, 32'd1);
    chk("t5_b1_fwd", {15'd0, m_tx_tvalid[0], m_tx_tdata[15:0]}, 32'h15002);
    tick;
    set_ufcd(0, 1'b1, 16'h5003, 1'b0); #1;
    chk("t5_len_err_once", {31'd0, ufc_len_err[0]}, 32'd0);
    chk("t5_idle_no_ufcd", {30'd0, m_tx_tvalid[0], s_ufcd_tready[0]}, 32'd0);
    set_ufcd(0, 1'b0, 16'h0, 1'b0);
    chk("t5_stat_ufc", {16'd0, stat_ufc[15:0]}, {16'd0, exp_stat(1)});

    // 6: reset during UFC_PAY on lane 1, then saturate lane 0 frame count
    s_ufc_tvalid[1] = 1'b1;
    s_ufc_tsize[5:3] = 3'd7;
    tick;
    tick;
    s_ufc_tvalid[1] = 1'b0;
    set_ufcd(1, 1'b1, 16'h6001, 1'b0); #1;
    chk("t6_pay_active", {31'd0, m_tx_tvalid[1]}, 32'd1);
    reset = 1'b1;
    tick; #1;
    chk("t6_rst_ufcd_ready", {31'd0, s_ufcd_tready[1]}, 32'd0);
    chk("t6_rst_tx_valid", {28'd0, m_tx_tvalid}, 32'd0);
    chk("t6_rst_m_ufc_tvalid", {28'd0, m_ufc_tvalid}, 32'd0);
    chk("t6_rst_pulses", {24'd0, frame_abort, ufc_len_err}, 32'd0);
    chk("t6_rst_stats", stat_frames[31:0] | stat_frames[63:32] | stat_ufc[31:0] | stat_ufc[63:32], 32'd0);
    reset = 1'b0;
    set_ufcd(1, 1'b0, 16'h0, 1'b0);
    tick;
    set_data(0, 1'b1, 16'h7777, 1'b1);
    repeat (65540) @(posedge user_clk);
    #1;
    set_data(0, 1'b0, 16'h0, 1'b0); #1;
    chk("t6_stat_saturate", {16'd0, stat_frames[15:0]}, {16'd0, exp_stat(65540)});
    tick;

    // Randomized frames and UFC messages on lane 2 against the ordered-stream model
    nf = 0;
    nu = 0;
    mon_en = 1'b1;
    rnd_en = 1'b1;
    tick;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        sz = 3'($urandom_range(0, 7));
        hdr_q.push_back(sz);
        s_ufc_tsize[8:6] = sz;
        s_ufc_tvalid[2] = 1'b1;
        wait_hs(1, "rnd_hdr");
        s_ufc_tvalid[2] = 1'b0;
        nu++;
        for (int b = 0; b <= int'(sz); b++) begin
          d = 16'($urandom);
          exp_q.push_back({1'b0, 2'b11, d});
          set_ufcd(2, 1'b1, d, (b == int'(sz)));
          wait_hs(2, "rnd_ufcd");
          set_ufcd(2, 1'b0, 16'h0, 1'b0);
        end
      end else begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          d = 16'($urandom);
          k = 2'($urandom_range(1, 3));
          exp_q.push_back({(b == len - 1), k, d});
          s_data_tdata[47:32] = d;
          s_data_tkeep[5:4]   = k;
          s_data_tlast[2]     = (b == len - 1);
          s_data_tvalid[2]    = 1'b1;
          wait_hs(0, "rnd_data");
          s_data_tvalid[2] = 1'b0;
        end
        nf++;
      end
      repeat ($urandom_range(0, 2)) tick;
    end
    rnd_en = 1'b0;
    m_tx_tready[2] = 1'b1;
    m_ufc_tready[2] = 1'b1;
    repeat (3) tick;
    mon_en = 1'b0;
    chk("rnd_beats_left", exp_q.size(), 32'd0);
    chk("rnd_hdrs_left", hdr_q.size(), 32'd0);
    chk("rnd_stat_frames", {16'd0, stat_frames[47:32]}, {16'd0, exp_stat(nf)});
    chk("rnd_stat_ufc", {16'd0, stat_ufc[47:32]}, {16'd0, exp_stat(nu)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
